// File: rtl/acc_result_requant.sv
// acc_result_requant: rounds, shifts and saturates wide signed accumulator
// results to a narrow signed width, tags frame boundaries, and buffers the
// samples in a first-word-fall-through FIFO drained by a valid/ready stream.
// Input side is valid-only: when the FIFO cannot take a sample it is dropped
// and a sticky overflow flag is raised.
module acc_result_requant #(
    parameter int WIDTH_IN       = 19,
    parameter int WIDTH_OUT      = 8,
    parameter int SHIFT          = 8,
    parameter int AMOUNT_OF_DATA = 16,
    parameter int DEPTH          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_IN-1:0]      data_in,
    input  logic                     valid_in,
    output logic [WIDTH_OUT-1:0]     data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [15:0]              sat_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (AMOUNT_OF_DATA > 1) ? $clog2(AMOUNT_OF_DATA) : 1;

    // Rounding constant: half an LSB of the shifted result (none for SHIFT=0).
    localparam logic [WIDTH_IN:0] ONE = {{WIDTH_IN{1'b0}}, 1'b1};
    localparam logic [WIDTH_IN:0] RND = (SHIFT == 0) ? '0 : (ONE << ((SHIFT > 0) ? SHIFT - 1 : 0));

    // Output range limits expressed at the widened (WIDTH_IN+1) width.
    localparam logic signed [WIDTH_IN:0] OMAX = {{(WIDTH_IN + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [WIDTH_IN:0] OMIN = {{(WIDTH_IN + 2 - WIDTH_OUT){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

    localparam logic [CW-1:0] LAST_IDX = CW'(AMOUNT_OF_DATA - 1);
    localparam logic [AW:0]   FULL_LVL = {1'b1, {AW{1'b0}}};

    // One FIFO entry carries the sample together with its frame-last tag.
    typedef struct packed {
        logic                 last;
        logic [WIDTH_OUT-1:0] data;
    } entry_t;

    // ---------------------------------------------------------------
    // Stage 1: requantisation and frame tagging
    // ---------------------------------------------------------------
    logic [WIDTH_IN:0]        sum;
    logic signed [WIDTH_IN:0] shr;
    logic                     sat_hi;
    logic                     sat_lo;
    entry_t                   s1_ent_d;
    entry_t                   s1_ent_q;
    logic                     s1_vld_q;
    logic [CW-1:0]            frame_d;
    logic [CW-1:0]            frame_q;
    logic [15:0]              sat_cnt_d;
    logic [15:0]              sat_cnt_q;

    // Round-half-up, arithmetic shift, then clamp into the output range.
    always_comb begin
        sum    = {data_in[WIDTH_IN-1], data_in} + RND;
        shr    = $signed(sum) >>> SHIFT;
        sat_hi = shr > OMAX;
        sat_lo = shr < OMIN;
        s1_ent_d.last = (frame_q == LAST_IDX);
        if (sat_hi) begin
            s1_ent_d.data = OMAX[WIDTH_OUT-1:0];
        end else if (sat_lo) begin
            s1_ent_d.data = OMIN[WIDTH_OUT-1:0];
        end else begin
            s1_ent_d.data = shr[WIDTH_OUT-1:0];
        end
    end

    // Frame index and saturation count advance on every accepted input,
    // including samples that are later dropped, so framing survives overflow.
    always_comb begin
        frame_d   = frame_q;
        sat_cnt_d = sat_cnt_q;
        if (valid_in) begin
            frame_d = (frame_q == LAST_IDX) ? '0 : frame_q + 1'b1;
            if ((sat_hi || sat_lo) && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 1'b1;
            end
        end
    end

    // Stage-1 pipeline register plus frame and saturation counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_ent_q  <= '0;
            frame_q   <= '0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= valid_in;
            frame_q   <= frame_d;
            sat_cnt_q <= sat_cnt_d;
            if (valid_in) begin
                s1_ent_q <= s1_ent_d;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: FWFT FIFO
    // ---------------------------------------------------------------
    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_d;
    logic [AW:0]     level_q;
    logic            ovf_q;
    logic            full;
    logic            not_empty;
    logic            push;
    logic            pop;
    logic            drop;

    // A full FIFO still takes a write when the head leaves on the same edge.
    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == FULL_LVL);
        pop       = not_empty && ready_i;
        push      = s1_vld_q && (!full || pop);
        drop      = s1_vld_q && full && !pop;
        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage array; contents are qualified by level_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_ent_q;
        end
    end

    // Head entry falls through; gated to zero when empty so that stale
    // storage never shows on data_o/last_o (including during reset).
    always_comb begin
        head    = mem_q[rd_ptr_q];
        valid_o = not_empty;
        data_o  = not_empty ? head.data : '0;
        last_o  = not_empty ? head.last : 1'b0;
    end

    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign sat_cnt_o  = sat_cnt_q;

endmodule

// File: doc/acc_result_requant.md
Name: acc_result_requant

Overview:
Downstream stage of the multiply-accumulate stream block. It consumes the wide signed accumulator results, which arrive as a valid-only stream with no backpressure. Each result is rounded, arithmetic-right-shifted and saturated to a narrow signed width, then buffered in a first-word-fall-through FIFO. Data leaves on a valid/ready stream with a frame-last marker every AMOUNT_OF_DATA results. Overflow and saturation status flags are provided for debug.

Parameters:
WIDTH_IN, 19, width of signed input result (2*8+4-1)
WIDTH_OUT, 8, width of signed output sample
SHIFT, 8, arithmetic right-shift amount; 0 to WIDTH_IN-1
AMOUNT_OF_DATA, 16, results per frame; last_o asserted on the final one
DEPTH, 32, FIFO depth; power of 2, at least AMOUNT_OF_DATA

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
data_in  in  WIDTH_IN  signed accumulator result
valid_in  in  1  data_in valid; no ready is returned upstream
data_o  out  WIDTH_OUT  signed requantised sample
valid_o  out  1  FIFO not empty
ready_i  in  1  downstream accepts data_o
last_o  out  1  data_o is the last sample of a frame
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
overflow_o  out  1  sticky; set when a sample is dropped on FIFO full
sat_cnt_o  out  16  saturation event count; saturates at 0xFFFF

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0:
  - valid_o=0, last_o=0, data_o=0, level_o=0, overflow_o=0, sat_cnt_o=0.
  - FIFO pointers, frame counter and stage register are cleared.
  - Reset mid-frame discards all buffered data; the next valid_in is frame index 0.
- Stage 1 (registered on the edge where valid_in=1):
  - Compute s = data_in + 2^(SHIFT-1) at WIDTH_IN+1 bits, sign-extended. For SHIFT=0 no rounding constant is added.
  - r = s >>> SHIFT (arithmetic shift). Rounding is round-half-up.
  - If r > 2^(WIDTH_OUT-1)-1, output 2^(WIDTH_OUT-1)-1. If r < -2^(WIDTH_OUT-1), output -2^(WIDTH_OUT-1). Either case is a saturation event and increments sat_cnt_o, which holds at 0xFFFF.
- Frame tagging at stage 1:
  - A frame counter counts 0..AMOUNT_OF_DATA-1 and wraps.
  - The tag last=1 when the counter equals AMOUNT_OF_DATA-1.
  - The counter advances on every valid_in, including samples later dropped, so frame alignment survives overflow.
- Stage 2 (FIFO write, one edge after stage 1):
  - Writes the sample and its last bit as a single entry.
  - Write when not full. When full, the write is still accepted if a pop occurs in the same cycle. Otherwise the sample is dropped and overflow_o is set; it stays set until reset.
- Output side (first-word-fall-through):
  - valid_o = level_o != 0.
  - data_o and last_o come from the head entry and are stable while valid_o=1 and ready_i=0.
  - Pop when valid_o and ready_i are both 1.
  - ready_i with an empty FIFO has no effect.
- Latency: from valid_in sampled at edge N into an empty FIFO, valid_o rises after edge N+1.
- Simultaneous push and pop: level_o is unchanged. This applies at any level, including an empty FIFO only if the entry was already present; there is no bypass.
- Throughput: one sample per clock in and out.
- Pointers wrap modulo DEPTH; full is detected by level_o == DEPTH.

Test Plan:
- Rounding, SHIFT=8, ready_i=1, one sample each:
  - data_in 384 -> data_o 2.
  - -384 -> -1.
  - 127 -> 0.
  - 128 -> 1.
  - valid_o rises 2 edges after the input.
- Saturation: data_in 32767 -> 127 and data_in -40000 -> -128. sat_cnt_o=2 and overflow_o=0.
- Framing: 2*AMOUNT_OF_DATA=32 consecutive samples with ready_i=1 -> last_o=1 only on outputs 15 and 31.
- Backpressure: ready_i=0 while 32 samples are written -> level_o=32 and overflow_o=0. A 33rd sample is dropped, overflow_o=1 and level_o stays 32. Then ready_i=1 drains 32 samples in order, last_o on outputs 15 and 31.
- Full with concurrent pop: at level 32 drive ready_i=1 and valid_in together -> no drop, level_o=32 and overflow_o=0.
- Reset mid-operation: assert rst=0 with level_o=10 and the frame counter at 5 -> all outputs are 0 immediately without waiting for a clock edge. After release, 16 samples give last_o on the 16th.
- Random: ready_i random at 50%, compared against a golden model -> zero mismatches.
